// File: rtl/frame_modulator.sv
// Bit-serial OOK frame modulator: latches a frame and serialises it MSB-first with
// programmable length, symbol time, repetition and NRZ/Manchester line coding.
module frame_modulator #(
  parameter int unsigned FRAME_BITS = 128,
  parameter int unsigned LEN_W      = $clog2(FRAME_BITS + 1),
  parameter int unsigned SYM_W      = 16,
  parameter int unsigned REP_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FRAME_BITS-1:0] in_bitstream,
  input  logic [LEN_W-1:0]      frame_len,
  input  logic [SYM_W-1:0]      symbol_time,
  input  logic [REP_W-1:0]      repetition_factor,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  wave_enable,
  output logic                  out,
  output logic [LEN_W-1:0]      bit_index
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [LEN_W-1:0]      lm1_q, lm1_d, bit_q, bit_d;
  logic [SYM_W-1:0]      tm1_q, tm1_d, half_q, half_d, cyc_q, cyc_d;
  logic [REP_W-1:0]      rm1_q, rm1_d, rep_q, rep_d;
  logic                  mode_q, mode_d;
  logic                  out_q, out_d, wave_q, wave_d, busy_q, busy_d, done_q, done_d;

  logic [SYM_W-1:0] t_eff;
  logic [REP_W-1:0] r_eff;
  logic [LEN_W-1:0] l_eff;
  logic             last_cyc, last_rep, last_bit, next_bit;

  // Effective frame parameters, normalised before latching so the counters compare
  // against terminal values directly and never overflow.
  always_comb begin
    t_eff = (symbol_time == '0) ? SYM_W'(1) : symbol_time;
    if (mode && (t_eff < SYM_W'(2))) t_eff = SYM_W'(2);
    r_eff = (repetition_factor == '0) ? REP_W'(1) : repetition_factor;
    l_eff = ((frame_len == '0) || (frame_len > LEN_W'(FRAME_BITS))) ? LEN_W'(FRAME_BITS)
                                                                    : frame_len;
  end

  assign last_cyc = (cyc_q == tm1_q);
  assign last_rep = (rep_q == rm1_q);
  assign last_bit = (bit_q == lm1_q);

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    lm1_d    = lm1_q;
    tm1_d    = tm1_q;
    half_d   = half_q;
    rm1_d    = rm1_q;
    mode_d   = mode_q;
    cyc_d    = cyc_q;
    rep_d    = rep_q;
    bit_d    = bit_q;
    next_bit = frame_q[FRAME_BITS-1];
    out_d    = 1'b0;
    wave_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StSend;
          frame_d = in_bitstream;
          lm1_d   = l_eff - LEN_W'(1);
          tm1_d   = t_eff - SYM_W'(1);
          half_d  = t_eff >> 1;
          rm1_d   = r_eff - REP_W'(1);
          mode_d  = mode;
          cyc_d   = '0;
          rep_d   = '0;
          bit_d   = '0;
          // First level of either coding is the bit itself.
          out_d   = in_bitstream[FRAME_BITS-1];
          wave_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StSend: begin
        if (abort) begin
          state_d = StIdle;
          cyc_d   = '0;
          rep_d   = '0;
          bit_d   = '0;
        end else if (last_cyc && last_rep && last_bit) begin
          state_d = StDone;
          done_d  = 1'b1;
          cyc_d   = '0;
          rep_d   = '0;
          bit_d   = '0;
        end else begin
          if (last_cyc) begin
            cyc_d = '0;
            if (last_rep) begin
              rep_d    = '0;
              bit_d    = bit_q + LEN_W'(1);
              frame_d  = frame_q << 1;
              next_bit = frame_q[FRAME_BITS-2];
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end else begin
            cyc_d = cyc_q + SYM_W'(1);
          end
          out_d  = (mode_q && (cyc_d >= half_q)) ? ~next_bit : next_bit;
          wave_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      frame_q <= '0;
      lm1_q   <= '0;
      tm1_q   <= '0;
      half_q  <= '0;
      rm1_q   <= '0;
      mode_q  <= 1'b0;
      cyc_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
      out_q   <= 1'b0;
      wave_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      lm1_q   <= lm1_d;
      tm1_q   <= tm1_d;
      half_q  <= half_d;
      rm1_q   <= rm1_d;
      mode_q  <= mode_d;
      cyc_q   <= cyc_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      out_q   <= out_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wave_enable = wave_q;
  assign out         = out_q;
  assign bit_index   = bit_q;

endmodule

// File: tb/tb_frame_modulator.sv
// Directed testbench for frame_modulator: per-cycle line levels, flags and bit_index
// against hand-computed waveforms.
module tb_frame_modulator;
  localparam int FB = 128;
  localparam int LW = 8;
  localparam int SW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FB-1:0] in_bitstream = '0;
  logic [LW-1:0] frame_len = '0;
  logic [SW-1:0] symbol_time = '0;
  logic [RW-1:0] repetition_factor = '0;
  logic          mode = 1'b0;
  logic          busy, done, wave_enable, out;
  logic [LW-1:0] bit_index;

  int pass_cnt = 0;
  int total_cnt = 0;

  frame_modulator #(
    .FRAME_BITS(FB),
    .LEN_W     (LW),
    .SYM_W     (SW),
    .REP_W     (RW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .in_bitstream     (in_bitstream),
    .frame_len        (frame_len),
    .symbol_time      (symbol_time),
    .repetition_factor(repetition_factor),
    .mode             (mode),
    .busy             (busy),
    .done             (done),
    .wave_enable      (wave_enable),
    .out              (out),
    .bit_index        (bit_index)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the sampling point of the first frame cycle.
  task automatic launch(input logic [FB-1:0] data, input logic [LW-1:0] len,
                        input logic [SW-1:0] t, input logic [RW-1:0] r, input logic m);
    in_bitstream      = data;
    frame_len         = len;
    symbol_time       = t;
    repetition_factor = r;
    mode              = m;
    start             = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    total_cnt++;
    if ({busy, done, wave_enable, out, bit_index} !== 12'h000)
      $display("FAIL reset_state got %b want 0", {busy, done, wave_enable, out, bit_index});
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nrz;
    logic [23:0] exp_w = 24'b111000111000000111000111;
    launch({8'hA5, 120'h0}, 8'd8, 16'd3, 4'd1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      total_cnt++;
      if ({busy, done, wave_enable, out} !== {3'b101, exp_w[23-i]})
        $display("FAIL nrz_cycle %0d got %b want %b", i + 1, {busy, done, wave_enable, out},
                 {3'b101, exp_w[23-i]});
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({busy, done, wave_enable, out} !== 4'b0100)
      $display("FAIL nrz_done got %b want 0100", {busy, done, wave_enable, out});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, wave_enable, out} !== 4'b0000)
      $display("FAIL nrz_idle got %b want 0000", {busy, done, wave_enable, out});
    else pass_cnt++;
  endtask

  task automatic test_manchester;
    logic [31:0] exp_w = 32'b11001100_00110011_11001100_00110011;
    launch({4'b1010, 124'h0}, 8'd4, 16'd4, 4'd2, 1'b1);
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      total_cnt++;
      if ({busy, done, wave_enable, out} !== {3'b101, exp_w[31-i]} || bit_index !== LW'(i / 8))
        $display("FAIL manch_cycle %0d got %b idx %0d want %b idx %0d", i + 1,
                 {busy, done, wave_enable, out}, bit_index, {3'b101, exp_w[31-i]}, i / 8);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({busy, done, wave_enable, out} !== 4'b0100)
      $display("FAIL manch_done got %b want 0100", {busy, done, wave_enable, out});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_full_len;
    logic [FB-1:0] data = 128'h0123456789ABCDEF_FEDCBA9876543210;
    launch(data, 8'd0, 16'd1, 4'd0, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      total_cnt++;
      if ({busy, done, wave_enable, out} !== {3'b101, data[127-i]} || bit_index !== LW'(i))
        $display("FAIL full_cycle %0d got %b idx %0d want %b idx %0d", i + 1,
                 {busy, done, wave_enable, out}, bit_index, {3'b101, data[127-i]}, i);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({busy, done, wave_enable, out} !== 4'b0100)
      $display("FAIL full_done got %b want 0100", {busy, done, wave_enable, out});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int done_seen = 0;
    launch({FB{1'b1}}, 8'd16, 16'd5, 4'd1, 1'b0);
    start = 1'b0;
    repeat (9) @(negedge clk);
    total_cnt++;
    if ({busy, wave_enable, out} !== 3'b111)
      $display("FAIL abort_pre got %b want 111", {busy, wave_enable, out});
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++;
    if ({busy, done, wave_enable, out, bit_index} !== 12'h000)
      $display("FAIL abort_post got %b want 0", {busy, done, wave_enable, out, bit_index});
    else pass_cnt++;
    for (int i = 0; i < 100; i++) begin
      if (done || wave_enable) done_seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL abort_quiet got %0d active cycles want 0", done_seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    int done_seen = 0;
    logic [3:0] exp_t [3] = '{4'b1011, 4'b1010, 4'b0100};
    launch({FB{1'b1}}, 8'd128, 16'd4, 4'd1, 1'b0);
    start = 1'b0;
    repeat (20) @(negedge clk);
    total_cnt++;
    if ({busy, wave_enable, out} !== 3'b111)
      $display("FAIL rst_pre got %b want 111", {busy, wave_enable, out});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, wave_enable, out, bit_index} !== 12'h000)
      $display("FAIL rst_async got %b want 0", {busy, done, wave_enable, out, bit_index});
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || wave_enable) done_seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL rst_quiet got %0d active cycles want 0", done_seen);
    else pass_cnt++;
    launch({2'b10, 126'h0}, 8'd2, 16'd1, 4'd1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({busy, done, wave_enable, out} !== exp_t[i])
        $display("FAIL rst_restart %0d got %b want %b", i + 1, {busy, done, wave_enable, out},
                 exp_t[i]);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_idle_abort;
    start = 1'b1;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, wave_enable, out} !== 4'b0000)
      $display("FAIL idle_abort got %b want 0000", {busy, done, wave_enable, out});
    else pass_cnt++;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_t [11] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0100, 4'b0000,
                               4'b1010, 4'b1010, 4'b1011, 4'b1011, 4'b0100};
    launch({2'b11, 126'h0}, 8'd2, 16'd2, 4'd1, 1'b0);
    in_bitstream = {2'b01, 126'h0};
    for (int i = 0; i < 11; i++) begin
      total_cnt++;
      if ({busy, done, wave_enable, out} !== exp_t[i])
        $display("FAIL b2b_cycle %0d got %b want %b", i + 1, {busy, done, wave_enable, out},
                 exp_t[i]);
      else pass_cnt++;
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_nrz;
    test_manchester;
    test_full_len;
    test_abort;
    test_reset_mid_frame;
    test_idle_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
